// File: rtl/bytebasher_pkg.sv
// bytebasher_pkg: shared constants and state encoding for the game datapath
package bytebasher_pkg;
    localparam logic [3:0]  BOX_NONE       = 4'd0;
    localparam int          NUM_BOXES_DFLT = 9;
    localparam logic [15:0] LFSR_TAPS      = 16'hB400;
    typedef enum logic [1:0] {IDLE, GAP, PICK, SHOW} state_t;
endpackage

// File: rtl/ms_tick_gen.sv
// ms_tick_gen: one-cycle tick every TICK_DIV clocks, restartable by clr
module ms_tick_gen #(
    parameter int TICK_DIV = 50000
) (
    input  logic clk,
    input  logic resetn,
    input  logic clr,
    output logic o_tick
);
    localparam int CW = TICK_DIV > 1 ? $clog2(TICK_DIV) : 1;
    logic [CW-1:0] r_cnt;
    assign o_tick = (r_cnt == CW'(TICK_DIV - 1));
    // divider count restarts on clr so the first tick lands TICK_DIV cycles later
    always_ff @(posedge clk or negedge resetn)
        if (!resetn) r_cnt <= '0;
        else r_cnt <= (clr || o_tick) ? '0 : r_cnt + 1'b1;
endmodule

// File: rtl/mole_scheduler.sv
// mole_scheduler: picks lit targets, times dwell/gap, judges hits and keeps score
module mole_scheduler
    import bytebasher_pkg::*;
#(
    parameter int          TICK_DIV  = 50000,
    parameter int          NUM_BOXES = NUM_BOXES_DFLT,
    parameter int          DWELL_MS  = 1000,
    parameter int          GAP_MS    = 250,
    parameter int          SCORE_W   = 8,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               i_enable,
    input  logic               i_clear,
    input  logic [3:0]         i_box_address,
    output logic [3:0]         o_target,
    output logic               o_hit_pulse,
    output logic               o_correct_pulse,
    output logic               o_wrong_pulse,
    output logic               o_miss_pulse,
    output logic [SCORE_W-1:0] o_score,
    output logic [SCORE_W-1:0] o_misses
);
    localparam int         MS_MAX  = DWELL_MS > GAP_MS ? DWELL_MS : GAP_MS;
    localparam int         MS_W    = $clog2(MS_MAX + 1);
    localparam logic [3:0] MAX_BOX = 4'(NUM_BOXES);

    logic [3:0]         r_s1, r_s2, r_prev, r_target, r_last;
    logic               r_armed;
    logic [15:0]        r_lfsr;
    state_t             r_state, w_next;
    logic [MS_W-1:0]    r_ms;
    logic [SCORE_W-1:0] r_score, r_misses;
    logic [SCORE_W:0]   w_miss_sum;
    logic [3:0]         w_cand;
    logic               w_tick, w_entry, w_press, w_show, w_cand_ok, w_timeout, w_gap_done;

    ms_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
        .clk    (clk),
        .resetn (resetn),
        .clr    (w_entry),
        .o_tick (w_tick)
    );

    assign w_press    = (r_s2 == r_prev) && (r_s2 != BOX_NONE) && r_armed && (r_s2 <= MAX_BOX);
    assign w_cand     = r_lfsr[3:0];
    assign w_cand_ok  = (w_cand != BOX_NONE) && (w_cand <= MAX_BOX) && (w_cand != r_last);
    assign w_timeout  = (r_ms == MS_W'(DWELL_MS));
    assign w_gap_done = (r_ms == MS_W'(GAP_MS));
    assign w_show     = i_enable && (r_state == SHOW);
    assign w_entry    = (w_next != r_state);

    assign o_hit_pulse     = w_show && w_press;
    assign o_correct_pulse = o_hit_pulse && (r_s2 == r_target);
    assign o_wrong_pulse   = o_hit_pulse && (r_s2 != r_target);
    assign o_miss_pulse    = w_show && w_timeout && !o_correct_pulse;
    assign o_target        = r_target;
    assign o_score         = r_score;
    assign o_misses        = r_misses;

    assign w_miss_sum = {1'b0, r_misses} + (SCORE_W+1)'(o_wrong_pulse) + (SCORE_W+1)'(o_miss_pulse);

    // next state: a correct hit or a timeout ends the mole; dropping enable parks in IDLE
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: w_next = GAP;
            GAP:  w_next = w_gap_done ? PICK : GAP;
            PICK: w_next = w_cand_ok ? SHOW : PICK;
            SHOW: w_next = (o_correct_pulse || o_miss_pulse) ? GAP : SHOW;
        endcase
        if (!i_enable) w_next = IDLE;
    end

    // synchronizer, one-press-per-touch arming and the free-running LFSR
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_s1    <= BOX_NONE;
            r_s2    <= BOX_NONE;
            r_prev  <= BOX_NONE;
            r_armed <= 1'b1;
            r_lfsr  <= LFSR_SEED;
        end else begin
            r_s1    <= i_box_address;
            r_s2    <= r_s1;
            r_prev  <= r_s2;
            r_armed <= w_press ? 1'b0 : (r_s2 == BOX_NONE) ? 1'b1 : r_armed;
            r_lfsr  <= r_lfsr[0] ? ((r_lfsr >> 1) ^ LFSR_TAPS) : (r_lfsr >> 1);
        end
    end

    // state register and ms timer, which restarts on every state change
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= IDLE;
            r_ms    <= '0;
        end else begin
            r_state <= w_next;
            r_ms    <= w_entry ? '0 : r_ms + MS_W'(w_tick);
        end
    end

    // target is lit only while heading into or staying in SHOW; remember it to avoid repeats
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_target <= BOX_NONE;
            r_last   <= BOX_NONE;
        end else begin
            r_target <= (w_next != SHOW) ? BOX_NONE : (r_state == PICK) ? w_cand : r_target;
            r_last   <= (r_state == PICK && w_next == SHOW) ? w_cand : r_last;
        end
    end

    // saturating score/miss counters; clear has priority over any increment
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_score  <= '0;
            r_misses <= '0;
        end else begin
            r_score  <= i_clear ? '0 : (o_correct_pulse && ~&r_score) ? r_score + 1'b1 : r_score;
            r_misses <= i_clear ? '0 : w_miss_sum[SCORE_W] ? '1 : w_miss_sum[SCORE_W-1:0];
        end
    end
endmodule

// File: tb/tb_mole_scheduler.sv
// tb_mole_scheduler: directed checks of target timing, hit judging and counters
module tb_mole_scheduler;
    logic       clk = 1'b0, resetn = 1'b0, i_enable = 1'b0, i_clear = 1'b0;
    logic [3:0] i_box_address = 4'd0;
    logic [3:0] o_target;
    logic       o_hit_pulse, o_correct_pulse, o_wrong_pulse, o_miss_pulse;
    logic [7:0] o_score, o_misses;
    int n_vec = 0, n_bad = 0, cyc = 0;
    int n_hit = 0, n_cor = 0, n_wrong = 0, n_miss = 0;
    int h0, c0, w0, m0, c_mark, k;
    logic [3:0] t, t2;

    mole_scheduler #(.TICK_DIV(4), .DWELL_MS(10), .GAP_MS(2)) dut (
        .clk             (clk),
        .resetn          (resetn),
        .i_enable        (i_enable),
        .i_clear         (i_clear),
        .i_box_address   (i_box_address),
        .o_target        (o_target),
        .o_hit_pulse     (o_hit_pulse),
        .o_correct_pulse (o_correct_pulse),
        .o_wrong_pulse   (o_wrong_pulse),
        .o_miss_pulse    (o_miss_pulse),
        .o_score         (o_score),
        .o_misses        (o_misses)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) begin
        n_hit   += int'(o_hit_pulse);
        n_cor   += int'(o_correct_pulse);
        n_wrong += int'(o_wrong_pulse);
        n_miss  += int'(o_miss_pulse);
    end

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic wait_tgt(output logic [3:0] tt);
        int j = 0;
        while (o_target == 4'd0 && j < 300) begin
            step(1);
            j++;
        end
        if (o_target == 4'd0) chk("target_timeout", 32'd0, 32'd1);
        tt = o_target;
    endtask

    task automatic hit(input logic [3:0] tt);
        i_box_address = tt;
        step(4);
        i_box_address = 4'd0;
        step(3);
    endtask

    task automatic snap();
        h0 = n_hit; c0 = n_cor; w0 = n_wrong; m0 = n_miss;
    endtask

    initial begin
        step(3);
        chk("rst_target", o_target, 0);
        chk("rst_score", o_score, 0);
        chk("rst_misses", o_misses, 0);
        chk("rst_pulse", o_hit_pulse | o_miss_pulse, 0);
        resetn = 1'b1;
        step(20);
        chk("idle_target", o_target, 0);

        // correct hit with exact pulse latency
        i_enable = 1'b1;
        wait_tgt(t);
        chk("tgt_range", t >= 1 && t <= 9, 1);
        snap();
        i_box_address = t;
        step(2);
        chk("early_pulse", o_hit_pulse, 0);
        step(1);
        chk("hit_pulse", o_hit_pulse, 1);
        chk("cor_pulse", o_correct_pulse, 1);
        step(1);
        c_mark = cyc;
        chk("hit_score", o_score, 1);
        chk("hit_clr_tgt", o_target, 0);
        chk("hit_counts", (n_hit - h0) * 100 + (n_cor - c0) * 10 + (n_wrong - w0), 110);
        step(1);
        i_box_address = 4'd0;
        wait_tgt(t2);
        chk("gap_len", (cyc - c_mark) >= 10 && (cyc - c_mark) <= 60, 1);
        chk("no_repeat", t2 != t, 1);

        // wrong press then timeout, measured from SHOW entry
        c_mark = cyc;
        snap();
        i_box_address = 4'((int'(t2) % 9) + 1);
        step(3);
        chk("wrong_pulse", o_wrong_pulse, 1);
        chk("wrong_not_cor", o_correct_pulse, 0);
        step(1);
        chk("wrong_misses", o_misses, 1);
        chk("wrong_keeps_tgt", o_target, t2);
        i_box_address = 4'd0;
        k = 0;
        while (!o_miss_pulse && k < 100) begin
            step(1);
            k++;
        end
        chk("miss_time", cyc - c_mark, 40);
        step(1);
        chk("miss_misses", o_misses, 2);
        chk("miss_clr_tgt", o_target, 0);
        chk("miss_counts", (n_miss - m0) * 10 + (n_wrong - w0), 11);

        // held button scores only once across several moles
        wait_tgt(t);
        snap();
        i_box_address = t;
        step(200);
        chk("held_hits", n_hit - h0, 1);
        chk("held_cor", n_cor - c0, 1);
        chk("held_score", o_score, 2);
        i_box_address = 4'd0;
        k = 0;
        while (o_target != 4'd0 && k < 100) begin
            step(1);
            k++;
        end
        wait_tgt(t);
        snap();
        hit(t);
        chk("rearm_cor", n_cor - c0, 1);
        chk("rearm_score", o_score, 3);

        // clear in the increment cycle wins
        wait_tgt(t);
        snap();
        i_box_address = t;
        step(3);
        chk("clr_cor_pulse", o_correct_pulse, 1);
        i_clear = 1'b1;
        step(1);
        i_clear = 1'b0;
        chk("clr_score", o_score, 0);
        chk("clr_misses", o_misses, 0);
        step(1);
        i_box_address = 4'd0;
        step(2);

        // saturation
        snap();
        repeat (255) begin
            wait_tgt(t);
            hit(t);
        end
        chk("sat_reach", o_score, 255);
        chk("sat_count", n_cor - c0, 255);
        snap();
        wait_tgt(t);
        hit(t);
        chk("sat_hold_cor", n_cor - c0, 1);
        chk("sat_hold", o_score, 255);
        chk("sat_misses", o_misses, 0);

        // out-of-range code ignored and leaves arming intact
        wait_tgt(t);
        snap();
        i_box_address = 4'hC;
        step(6);
        chk("invalid_hits", n_hit - h0, 0);
        i_box_address = t;
        step(3);
        chk("after_invalid_cor", o_correct_pulse, 1);
        step(1);
        i_box_address = 4'd0;
        step(3);

        // enable low drops the target
        wait_tgt(t);
        i_enable = 1'b0;
        step(1);
        chk("dis_target", o_target, 0);
        snap();
        i_box_address = t;
        step(6);
        i_box_address = 4'd0;
        chk("dis_no_pulse", n_hit - h0, 0);
        step(3);
        i_enable = 1'b1;

        // async reset mid-SHOW
        wait_tgt(t);
        @(negedge clk);
        #2;
        resetn = 1'b0;
        #1;
        chk("arst_target", o_target, 0);
        chk("arst_score", o_score, 0);
        chk("arst_misses", o_misses, 0);
        step(3);
        resetn = 1'b1;
        c_mark = cyc;
        wait_tgt(t);
        chk("arst_regap", (cyc - c_mark) >= 11, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule

// File: doc/mole_scheduler.md
Name: mole_scheduler

Overview:
- Sequences the active-game datapath: picks the lit target box from an internal LFSR and times each mole's dwell and the gap between moles.
- Judges debounced hits from the Arduino box address and keeps the score and miss counters.
- Sits below the top-level game control FSM. That FSM enables it during the active game and clears it at game start. Its target drives the VGA/LED datapath.

Parameters:
- TICK_DIV, 50000: clk cycles per 1 ms tick (50 MHz clock).
- NUM_BOXES, 9: valid box addresses are 1..NUM_BOXES; 0 means none.
- DWELL_MS, 1000: ms a mole stays lit before it counts as a miss.
- GAP_MS, 250: ms with no mole between targets.
- SCORE_W, 8: width of the score and miss counters.
- LFSR_SEED, 16'hACE1: LFSR reset value; must be non-zero.

Ports:
- clk  in  1  system clock.
- resetn  in  1  asynchronous active-low reset.
- i_enable  in  1  level from game control; high while the game is active.
- i_clear  in  1  one-cycle synchronous clear of score and misses.
- i_box_address  in  4  raw Arduino box code, asynchronous to clk; 0 = no press.
- o_target  out  4  currently lit box; 0 = none.
- o_hit_pulse  out  1  one-cycle pulse on any accepted press while a mole is shown.
- o_correct_pulse  out  1  one-cycle pulse when the press matches o_target.
- o_wrong_pulse  out  1  one-cycle pulse when the press does not match o_target.
- o_miss_pulse  out  1  one-cycle pulse when the dwell expires.
- o_score  out  SCORE_W  count of correct hits.
- o_misses  out  SCORE_W  count of wrong presses plus timeouts.

Behaviour:
- Reset (resetn low, async):
  - State IDLE, o_target=0, all pulses 0, o_score=0, o_misses=0.
  - LFSR=LFSR_SEED, armed=1, ms timer=0, sync flops=0.
- Input conditioning:
  - 2-FF synchronizer on i_box_address gives s2; prev holds s2 from one cycle earlier.
  - Press event = (s2==prev) && s2!=0 && armed && s2<=NUM_BOXES.
  - A press event clears armed. armed sets again when s2==0 for one cycle.
  - Addresses above NUM_BOXES are ignored and do not clear armed.
  - Pulse latency: a pulse is high in the cycle after the 3rd rising edge following a stable input change.
- LFSR: 16-bit Galois, taps 16'hB400, advances every cycle, including in IDLE.
- ms timer: driven by a 1-cycle tick every TICK_DIV clocks. It counts ticks and is zeroed on every state entry.
- States:
  - IDLE: o_target=0. If i_enable, go to GAP.
  - GAP: o_target=0. When the timer reaches GAP_MS, go to PICK.
  - PICK: candidate = lfsr[3:0].
    - Accept if 1<=candidate<=NUM_BOXES and candidate != the previous target.
    - On accept: o_target<=candidate, go to SHOW.
    - Otherwise retry next cycle. The LFSR period guarantees termination.
  - SHOW:
    - Press == o_target: hit+correct pulses, score+1, o_target<=0, go to GAP.
    - Press != o_target: hit+wrong pulses, misses+1, stay in SHOW with the timer not reset.
    - Timer reaches DWELL_MS: miss pulse, misses+1, o_target<=0, go to GAP.
- Priorities and boundaries:
  - Correct hit in the same cycle as the timeout: the hit wins and no miss is counted.
  - i_enable low in any state: IDLE on the next edge, o_target=0, no pulses, counters held.
  - i_clear beats any increment in the same cycle and is legal in any state.
  - Counters saturate at all-ones and do not wrap.
  - Press events outside SHOW are consumed (armed cleared) but produce no pulses.
  - The previous target resets to 0 on resetn and is not cleared by i_enable.

Decomposition:
- Shared package bytebasher_pkg holds:
  - BOX_NONE=4'd0.
  - The state encoding IDLE/GAP/PICK/SHOW.
  - The LFSR tap constant 16'hB400.
  - NUM_BOXES default.
- Sub-module ms_tick_gen (param TICK_DIV; ports clk, resetn, clr, o_tick) generates the 1 ms tick.

Test Plan:
(All tests use TICK_DIV=4, DWELL_MS=10, GAP_MS=2.)
- Reset check: pulse resetn low mid-SHOW → o_target=0, o_score=0, o_misses=0 immediately (async); with i_enable high, re-enters GAP after resetn rises.
- Correct hit: raise i_enable, wait for o_target=T, drive i_box_address=T for 5 cycles then 0 → one o_hit_pulse and one o_correct_pulse, o_score=1, o_target=0, next target ≠ T after 8 cycles of GAP.
- Wrong press then timeout: at o_target=T, press T%9+1 → o_wrong_pulse, o_misses=1, o_target still T; no further input → o_miss_pulse 40 cycles after SHOW entry, o_misses=2.
- Held button: hold i_box_address=T for 200 cycles across two moles → exactly one press event; release then re-press on the new target scores.
- Clear beats increment: assert i_clear in the same cycle as the correct-hit increment → o_score=0.
- Saturation and invalid input: with score preset to 8'hFF, a correct hit keeps 8'hFF; i_box_address=4'hC → no pulses.
